// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control-bundle layout, opcodes and forward-select encodings
// Bundle layout, MSB first:
//   {RegDst,RegWrite,MemtoReg,MemRead,MemWrite,BranchEqual,BranchnotEqual,
//    ALUSrc,Issigned,ALUop[3:0]}
package ctrl_pkg;

    localparam int CTRL_W = 13;

    localparam int B_REGDST    = 12;
    localparam int B_REGWRITE  = 11;
    localparam int B_MEMTOREG  = 10;
    localparam int B_MEMREAD   = 9;
    localparam int B_MEMWRITE  = 8;
    localparam int B_BEQ       = 7;
    localparam int B_BNE       = 6;
    localparam int B_ALUSRC    = 5;
    localparam int B_ISSIGNED  = 4;
    localparam int B_ALUOP_MSB = 3;
    localparam int B_ALUOP_LSB = 0;

    localparam logic [5:0] OP_LW   = 6'h12;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LBU  = 6'h22;
    localparam logic [5:0] OP_SB   = 6'h28;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_R    = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h09;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_BEQ  = 6'h05;
    localparam logic [5:0] OP_BNE  = 6'h04;
    localparam logic [5:0] OP_JAL  = 6'h07;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ORI  = 6'h0e;

    // A bubble is indistinguishable from an opcode-0x0 instruction.
    localparam logic [CTRL_W-1:0] BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_t;

    // True when a writing stage targets a nonzero register equal to r.
    function automatic logic reg_hit(input logic we, input logic [4:0] w, input logic [4:0] r);
        return we && (w != 5'd0) && (w == r);
    endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard.sv
// hazard_unit: combinational branch resolution, stall detection and forward selects
// Optional feature macro: CTRL_PIPELINE_FORWARD_EN
//   defined   -> EX/MEM and MEM/WB forwarding, stall only on load-use
//   undefined -> no forwarding, stall on any RAW against ID/EX or EX/MEM
// Ports:
//   ex_zero                       ALU zero flag of the instruction in EX
//   idex_beq/bne/mem_read/reg_write  selected ID/EX control bits
//   idex_wreg/rs/rt               ID/EX register indices
//   exmem_reg_write/exmem_wreg    EX/MEM writer
//   memwb_reg_write/memwb_wreg    MEM/WB writer
//   id_rs/id_rt                   source fields of the instruction in ID
//   branch_taken                  taken branch in EX
//   stall                         hold PC and IF/ID, bubble ID/EX
//   fwd_a/fwd_b                   ALU operand forward selects
module hazard_unit
    import ctrl_pkg::*;
(
    input  logic       ex_zero,
    input  logic       idex_beq,
    input  logic       idex_bne,
    input  logic       idex_mem_read,
    input  logic       idex_reg_write,
    input  logic [4:0] idex_wreg,
    input  logic [4:0] idex_rs,
    input  logic [4:0] idex_rt,
    input  logic       exmem_reg_write,
    input  logic [4:0] exmem_wreg,
    input  logic       memwb_reg_write,
    input  logic [4:0] memwb_wreg,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       branch_taken,
    output logic       stall,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

`ifdef CTRL_PIPELINE_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic load_use;
    logic raw_stall;

    always_comb begin
        branch_taken = (idex_beq & ex_zero) | (idex_bne & ~ex_zero);
        load_use     = reg_hit(idex_mem_read, idex_wreg, id_rs) |
                       reg_hit(idex_mem_read, idex_wreg, id_rt);
        // Without forwarding a result is only usable once it reaches MEM/WB,
        // because the register file writes before it reads.
        raw_stall    = load_use |
                       reg_hit(idex_reg_write, idex_wreg, id_rs) |
                       reg_hit(idex_reg_write, idex_wreg, id_rt) |
                       reg_hit(exmem_reg_write, exmem_wreg, id_rs) |
                       reg_hit(exmem_reg_write, exmem_wreg, id_rt);
        stall        = FWD_EN ? load_use : raw_stall;
        // EX/MEM is checked first so the younger result wins a double match.
        fwd_a = !FWD_EN                                       ? FWD_RF  :
                reg_hit(exmem_reg_write, exmem_wreg, idex_rs) ? FWD_MEM :
                reg_hit(memwb_reg_write, memwb_wreg, idex_rs) ? FWD_WB  : FWD_RF;
        fwd_b = !FWD_EN                                       ? FWD_RF  :
                reg_hit(exmem_reg_write, exmem_wreg, idex_rt) ? FWD_MEM :
                reg_hit(memwb_reg_write, memwb_wreg, idex_rt) ? FWD_WB  : FWD_RF;
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: ID/EX, EX/MEM, MEM/WB control registers with stall/flush generation
// Optional feature macro: CTRL_PIPELINE_FORWARD_EN (operand forwarding, see hazard_unit)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_ctrl, id_jump              decoder bundle and jump flag for the instruction in ID
//   id_rs, id_rt, id_rd           register fields in ID
//   ex_zero                       ALU zero flag of the instruction in EX
//   pc_we, ifid_we, ifid_flush    front-end write enables and IF/ID clear
//   ex_branch_taken               taken branch resolved in EX
//   idex/exmem/memwb_ctrl         stage control registers
//   idex_rs, idex_rt              EX source indices
//   exmem_wreg, memwb_wreg        destination indices of MEM and WB
//   fwd_a, fwd_b                  ALU operand forward selects
//   stall_cnt, flush_cnt          saturating event counters
module ctrl_pipeline #(
    parameter int CTRL_W = ctrl_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_jump,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              ex_zero,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              ex_branch_taken,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [CTRL_W-1:0] exmem_ctrl,
    output logic [CTRL_W-1:0] memwb_ctrl,
    output logic [4:0]        idex_rs,
    output logic [4:0]        idex_rt,
    output logic [4:0]        exmem_wreg,
    output logic [4:0]        memwb_wreg,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import ctrl_pkg::*;

    logic [4:0] idex_wreg;
    logic [4:0] id_wreg;
    logic       hz_taken;
    logic       hz_stall;
    logic [1:0] hz_fwd_a;
    logic [1:0] hz_fwd_b;
    logic       advance;

    hazard_unit u_hazard (
        .ex_zero         (ex_zero),
        .idex_beq        (idex_ctrl[B_BEQ]),
        .idex_bne        (idex_ctrl[B_BNE]),
        .idex_mem_read   (idex_ctrl[B_MEMREAD]),
        .idex_reg_write  (idex_ctrl[B_REGWRITE]),
        .idex_wreg       (idex_wreg),
        .idex_rs         (idex_rs),
        .idex_rt         (idex_rt),
        .exmem_reg_write (exmem_ctrl[B_REGWRITE]),
        .exmem_wreg      (exmem_wreg),
        .memwb_reg_write (memwb_ctrl[B_REGWRITE]),
        .memwb_wreg      (memwb_wreg),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .branch_taken    (hz_taken),
        .stall           (hz_stall),
        .fwd_a           (hz_fwd_a),
        .fwd_b           (hz_fwd_b)
    );

    // A taken branch overrides the stall; a stalled jump flushes only once
    // the stall releases because its flush is gated by ~hz_stall.
    always_comb begin
        id_wreg         = id_ctrl[B_REGDST] ? id_rd : id_rt;
        ex_branch_taken = ~rst & hz_taken;
        pc_we           = ~rst & (ex_branch_taken | ~hz_stall);
        ifid_we         = pc_we;
        ifid_flush      = rst | ex_branch_taken | (~hz_stall & id_jump);
        advance         = ~rst & ~ex_branch_taken & ~hz_stall;
        fwd_a           = rst ? FWD_RF : hz_fwd_a;
        fwd_b           = rst ? FWD_RF : hz_fwd_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ctrl  <= BUBBLE;
            idex_rs    <= 5'd0;
            idex_rt    <= 5'd0;
            idex_wreg  <= 5'd0;
            exmem_ctrl <= BUBBLE;
            exmem_wreg <= 5'd0;
            memwb_ctrl <= BUBBLE;
            memwb_wreg <= 5'd0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            idex_ctrl  <= advance ? id_ctrl : BUBBLE;
            idex_rs    <= advance ? id_rs   : 5'd0;
            idex_rt    <= advance ? id_rt   : 5'd0;
            idex_wreg  <= advance ? id_wreg : 5'd0;
            exmem_ctrl <= idex_ctrl;
            exmem_wreg <= idex_wreg;
            memwb_ctrl <= exmem_ctrl;
            memwb_wreg <= exmem_wreg;
            if (!pc_we && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed scoreboard bench for ctrl_pipeline
// Counters are instantiated 4 bits wide so saturation is reachable in a few cycles.
module tb_ctrl_pipeline;

    localparam int CW = 4;

    localparam logic [12:0] NOP  = 13'h0000;
    localparam logic [12:0] LW   = 13'h0E30;
    localparam logic [12:0] ADD  = 13'h1812;
    localparam logic [12:0] ADDI = 13'h0830;
    localparam logic [12:0] BEQ  = 13'h0086;
    localparam logic [12:0] BNE  = 13'h0046;

    logic          clk = 1'b0;
    logic          rst;
    logic [12:0]   id_ctrl;
    logic          id_jump;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          ex_zero;
    logic          pc_we, ifid_we, ifid_flush, ex_branch_taken;
    logic [12:0]   idex_ctrl, exmem_ctrl, memwb_ctrl;
    logic [4:0]    idex_rs, idex_rt, exmem_wreg, memwb_wreg;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    ctrl_pipeline #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_ctrl         (id_ctrl),
        .id_jump         (id_jump),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .ex_zero         (ex_zero),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .ex_branch_taken (ex_branch_taken),
        .idex_ctrl       (idex_ctrl),
        .exmem_ctrl      (exmem_ctrl),
        .memwb_ctrl      (memwb_ctrl),
        .idex_rs         (idex_rs),
        .idex_rt         (idex_rt),
        .exmem_wreg      (exmem_wreg),
        .memwb_wreg      (memwb_wreg),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    // Expected outputs for one cycle; -1 means not checked.
    typedef struct {
        string nm;
        int pc, fl, br, idex, mw, fa, fb, sc, fc;
    } exp_t;

    exp_t q[$];
    int total  = 0;
    int passed = 0;

    // Column order: pc_we(=ifid_we), ifid_flush, branch, idex_ctrl, memwb_ctrl,
    // fwd_a, fwd_b, stall_cnt, flush_cnt
    function automatic exp_t mk(string n, int pc, int fl, int br, int idex, int mw,
                                int fa, int fb, int sc, int fc);
        exp_t e;
        e.nm = n; e.pc = pc; e.fl = fl; e.br = br; e.idex = idex; e.mw = mw;
        e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    function automatic exp_t nochk();
        return mk("-", -1, -1, -1, -1, -1, -1, -1, -1, -1);
    endfunction

    task automatic chk(input string nm, input string f, input int act, input int exp);
        if (exp >= 0) begin
            total++;
            if (act == exp) passed++;
            else $display("FAIL %s.%s actual=%0h expected=%0h", nm, f, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "pc_we",      int'(pc_we),           e.pc);
                chk(e.nm, "ifid_we",    int'(ifid_we),         e.pc);
                chk(e.nm, "ifid_flush", int'(ifid_flush),      e.fl);
                chk(e.nm, "br_taken",   int'(ex_branch_taken), e.br);
                chk(e.nm, "idex_ctrl",  int'(idex_ctrl),       e.idex);
                chk(e.nm, "memwb_ctrl", int'(memwb_ctrl),      e.mw);
                chk(e.nm, "fwd_a",      int'(fwd_a),           e.fa);
                chk(e.nm, "fwd_b",      int'(fwd_b),           e.fb);
                chk(e.nm, "stall_cnt",  int'(stall_cnt),       e.sc);
                chk(e.nm, "flush_cnt",  int'(flush_cnt),       e.fc);
            end
        end
    end

    task automatic step(input logic r, input logic [12:0] c, input logic j,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic z, input exp_t e);
        rst = r; id_ctrl = c; id_jump = j; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (3) step(0, NOP, 0, 0, 0, 0, 0, nochk());
    endtask

    initial begin
        rst = 1'b1; id_ctrl = NOP; id_jump = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; ex_zero = 1'b0;
        @(posedge clk);
        #1;
        // reset held, jump and zero flag must be ignored
        step(1, NOP, 1, 0, 0, 0, 0, mk("rst1", 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(1, NOP, 1, 0, 0, 0, 1, mk("rst2", 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(0, NOP, 0, 0, 0, 0, 0, mk("rel",  1, 0, 0, 0, 0, 0, 0, 0, 0));
        // load-use: lw r8 then add r10 = r8 + r9
        step(0, LW,  0, 0, 8, 0,  0, mk("ld_issue", 1, 0, 0, 0,  -1, -1, -1, 0, 0));
        step(0, ADD, 0, 8, 9, 10, 0, mk("ld_stall", 0, 0, 0, LW, -1, -1, -1, 0, 0));
`ifdef CTRL_PIPELINE_FORWARD_EN
        step(0, ADD, 0, 8, 9, 10, 0, mk("ld_release", 1, 0, 0, 0,   -1, -1, -1, 1, 0));
        step(0, NOP, 0, 0, 0, 0,  0, mk("ld_add_ex",  1, 0, 0, ADD, LW,  1,  0, 1, 0));
`else
        step(0, ADD, 0, 8, 9, 10, 0, mk("ld_stall2",  0, 0, 0, 0,   -1, 0, 0, 1, 0));
        step(0, ADD, 0, 8, 9, 10, 0, mk("ld_release", 1, 0, 0, 0,   LW, 0, 0, 2, 0));
        step(0, NOP, 0, 0, 0, 0,  0, mk("ld_add_ex",  1, 0, 0, ADD, -1, 0, 0, 2, 0));
`endif
        drain();
        // beq taken / not taken
        step(0, BEQ, 0, 1, 2, 0, 0, mk("beq_id",     1, 0, 0, -1,  -1, -1, -1, -1, 0));
        step(0, ADD, 0, 3, 4, 5, 1, mk("beq_taken",  1, 1, 1, BEQ, -1, -1, -1, -1, 0));
        step(0, NOP, 0, 0, 0, 0, 0, mk("beq_squash", 1, 0, 0, 0,   -1, -1, -1, -1, 1));
        step(0, BEQ, 0, 1, 2, 0, 0, mk("beq_id2",    1, 0, 0, -1,  -1, -1, -1, -1, 1));
        step(0, ADD, 0, 3, 4, 5, 0, mk("beq_nt",     1, 0, 0, BEQ, -1, -1, -1, -1, 1));
        step(0, NOP, 0, 0, 0, 0, 0, mk("beq_nt_add", 1, 0, 0, ADD, -1, -1, -1, -1, 1));
        // bne with the zero flag inverted
        step(0, BNE, 0, 1, 2, 0, 1, mk("bne_id",     1, 0, 0, -1,  -1, -1, -1, -1, 1));
        step(0, ADD, 0, 3, 4, 5, 0, mk("bne_taken",  1, 1, 1, BNE, -1, -1, -1, -1, 1));
        step(0, NOP, 0, 0, 0, 0, 1, mk("bne_squash", 1, 0, 0, 0,   -1, -1, -1, -1, 2));
        step(0, BNE, 0, 1, 2, 0, 0, mk("bne_id2",    1, 0, 0, -1,  -1, -1, -1, -1, 2));
        step(0, ADD, 0, 3, 4, 5, 1, mk("bne_nt",     1, 0, 0, BNE, -1, -1, -1, -1, 2));
        step(0, NOP, 0, 0, 0, 0, 0, mk("bne_nt_add", 1, 0, 0, ADD, -1, -1, -1, -1, 2));
        // jump in ID against taken bne in EX: one flush only
        step(0, BNE, 0, 1, 2, 0, 0, mk("j_bne_id",     1, 0, 0, -1,  -1, -1, -1, -1, 2));
        step(0, NOP, 1, 0, 0, 0, 0, mk("j_vs_br",      1, 1, 1, BNE, -1, -1, -1, -1, 2));
        step(0, NOP, 0, 0, 0, 0, 0, mk("j_squash",     1, 0, 0, 0,   -1, -1, -1, -1, 3));
        step(0, NOP, 1, 0, 0, 0, 0, mk("j_plain",      1, 1, 0, -1,  -1, -1, -1, -1, 3));
        step(0, NOP, 0, 0, 0, 0, 0, mk("j_plain_after", 1, 0, 0, -1, -1, -1, -1, -1, 4));
        // jump stalled behind a load-use flushes on release
        step(0, LW,  0, 0, 8, 0, 0, mk("jl_ld",    1, 0, 0, -1, -1, -1, -1, -1, 4));
        step(0, NOP, 1, 8, 0, 0, 0, mk("jl_stall", 0, 0, 0, LW, -1, -1, -1, -1, 4));
`ifdef CTRL_PIPELINE_FORWARD_EN
        step(0, NOP, 1, 8, 0, 0, 0, mk("jl_release", 1, 1, 0, 0, -1, -1, -1, -1, 4));
`else
        step(0, NOP, 1, 8, 0, 0, 0, mk("jl_stall2",  0, 0, 0, 0, -1, -1, -1, -1, 4));
        step(0, NOP, 1, 8, 0, 0, 0, mk("jl_release", 1, 1, 0, 0, -1, -1, -1, -1, 4));
`endif
        step(0, NOP, 0, 0, 0, 0, 0, mk("jl_after", 1, 0, 0, 0, -1, -1, -1, -1, 5));
        drain();
        // addi r5 then add r6 = r5 + r5
        step(0, ADDI, 0, 0, 5, 0, 0, mk("fw_addi", 1, 0, 0, -1, -1, -1, -1, -1, -1));
`ifdef CTRL_PIPELINE_FORWARD_EN
        step(0, ADD,  0, 5, 5, 6, 0, mk("fw_add_id", 1, 0, 0, ADDI, -1, -1, -1, -1, -1));
        step(0, NOP,  0, 0, 0, 0, 0, mk("fw_mem",    1, 0, 0, ADD,  -1,  2,  2, -1, -1));
        step(0, ADDI, 0, 0, 5, 0, 0, nochk());
        step(0, NOP,  0, 0, 0, 0, 0, nochk());
        step(0, ADD,  0, 5, 5, 6, 0, mk("fw_gap_id", 1, 0, 0, 0,   -1, -1, -1, -1, -1));
        step(0, NOP,  0, 0, 0, 0, 0, mk("fw_wb",     1, 0, 0, ADD, -1,  1,  1, -1, -1));
        step(0, ADDI, 0, 0, 5, 0, 0, nochk());
        step(0, ADDI, 0, 0, 5, 0, 0, nochk());
        step(0, ADD,  0, 5, 5, 6, 0, nochk());
        step(0, NOP,  0, 0, 0, 0, 0, mk("fw_both",   1, 0, 0, ADD, -1,  2,  2, -1, -1));
`else
        step(0, ADD,  0, 5, 5, 6, 0, mk("raw_stall1",  0, 0, 0, ADDI, -1, 0, 0, -1, -1));
        step(0, ADD,  0, 5, 5, 6, 0, mk("raw_stall2",  0, 0, 0, 0,    -1, 0, 0, -1, -1));
        step(0, ADD,  0, 5, 5, 6, 0, mk("raw_release", 1, 0, 0, 0,    -1, 0, 0, -1, -1));
        step(0, NOP,  0, 0, 0, 0, 0, mk("raw_add_ex",  1, 0, 0, ADD,  -1, 0, 0, -1, -1));
        step(0, ADDI, 0, 0, 5, 0, 0, nochk());
        step(0, NOP,  0, 0, 0, 0, 0, nochk());
        step(0, ADD,  0, 5, 5, 6, 0, mk("raw_gap_stall",   0, 0, 0, 0,   -1, 0, 0, -1, -1));
        step(0, ADD,  0, 5, 5, 6, 0, mk("raw_gap_release", 1, 0, 0, 0,   -1, 0, 0, -1, -1));
        step(0, NOP,  0, 0, 0, 0, 0, mk("raw_gap_ex",      1, 0, 0, ADD, -1, 0, 0, -1, -1));
`endif
        // writes to r0 never forward or stall
        step(0, ADDI, 0, 0, 0, 0, 0, nochk());
        step(0, ADD,  0, 0, 0, 7, 0, mk("r0_id", 1, 0, 0, ADDI, -1, -1, -1, -1, -1));
        step(0, NOP,  0, 0, 0, 0, 0, mk("r0_ex", 1, 0, 0, ADD,  -1,  0,  0, -1, -1));
        drain();
        // reset during a load-use stall discards everything in flight
        step(0, LW,  0, 0, 8, 0,  0, nochk());
        step(0, ADD, 0, 8, 9, 10, 0, mk("rs_stall", 0, 0, 0, LW, -1, -1, -1, -1, -1));
        step(1, ADD, 0, 8, 9, 10, 0, mk("rs_rst",   0, 1, 0, 0,  -1,  0,  0, -1, -1));
        step(0, NOP, 0, 0, 0, 0,  0, mk("rs_clean", 1, 0, 0, 0,   0,  0,  0,  0,  0));
        // saturate the stall counter with back-to-back dependent loads
        repeat (40) step(0, LW, 0, 8, 8, 0, 0, nochk());
        step(0, LW, 0, 8, 8, 0, 0, mk("sat1", -1, -1, -1, -1, -1, -1, -1, 15, 0));
        step(0, LW, 0, 8, 8, 0, 0, mk("sat2", -1, -1, -1, -1, -1, -1, -1, 15, 0));
        step(0, LW, 0, 8, 8, 0, 0, mk("sat3", -1, -1, -1, -1, -1, -1, -1, 15, 0));
        repeat (3) @(negedge clk);
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
